sram_rr_arbiter: RTL
====================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: SRAM word address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128: SRAM word width.
REQ-004 SHALL have parameter MASK_UNIT, default 8: bits covered by one write-mask bit.
REQ-005 SHALL have parameter MASK_WIDTH, default (DATA_WIDTH+MASK_UNIT-1)/MASK_UNIT: write-mask width.
REQ-006 SHALL have port clock, input, 1: single clock for all logic.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port req_valid, input, NUM_REQ: per-requester request valid.
REQ-009 SHALL have port req_ready, output, NUM_REQ: per-requester request accepted.
REQ-010 SHALL have port req_write, input, NUM_REQ: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH: requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 SHALL have port req_mask, input, NUM_REQ*MASK_WIDTH: per-requester write masks, packed likewise.
REQ-013 SHALL have port req_dataIn, input, NUM_REQ*DATA_WIDTH: per-requester write data, packed likewise.
REQ-014 SHALL have port resp_valid, output, NUM_REQ: read data valid for requester i.
REQ-015 SHALL have port resp_ready, input, NUM_REQ: requester i accepts read data.
REQ-016 SHALL have port resp_data, output, DATA_WIDTH: read data, shared by all requesters.
REQ-017 SHALL have ports sram_enable (output, 1), sram_write (output, 1), sram_addr (output, ADDR_WIDTH), sram_mask (output, MASK_WIDTH), sram_dataIn (output, DATA_WIDTH): one SRAM read/write port.
REQ-018 SHALL have port sram_dataOut, input, DATA_WIDTH: SRAM read data, registered in the SRAM, valid the cycle after the read enable.

Function
REQ-019 SHALL grant at most one requester per cycle; grant = req_valid[i] && req_ready[i].
REQ-020 SHALL drive sram_* combinationally from the granted requester in the grant cycle; sram_enable=0 and all other sram_* = 0 when there is no grant.
REQ-021 SHALL treat requester i as eligible when req_valid[i] && (req_write[i] || readAllowed).
REQ-022 SHALL define readAllowed = !inflight && (!holdValid || (resp_valid & resp_ready) != 0).
REQ-023 SHALL select, round-robin, the first eligible index starting at pointer ptr, wrapping NUM_REQ-1 -> 0.
REQ-024 SHALL set ptr to (granted index + 1) mod NUM_REQ after each grant, and hold ptr when there is no grant.
REQ-025 SHALL post writes, with no response: the SRAM is written at the end of the grant cycle.
REQ-026 SHALL, on a read grant in cycle T, set inflight=1 and record the requester id, capture sram_dataOut into the hold register at the end of T+1, and assert resp_valid[id] from T+2 until resp_ready[id]=1.
REQ-027 SHALL assert at most one resp_valid bit; resp_data SHALL hold its value while resp_valid is high.
REQ-028 SHALL allow write grants during inflight or while a response is held; reads SHALL sustain at most one grant every 2 cycles.
REQ-029 SHALL keep ptr unchanged when all req_valid = 0; a requester that is not granted SHALL see req_ready=0 and keep its request stable (valid/ready semantics).
REQ-030 SHALL ignore req_* fields when req_valid is low.

Reset
REQ-031 SHALL, on reset, clear ptr, inflight, holdValid, resp_valid, req_ready and sram_enable to 0, and clear resp_data to 0.
REQ-032 SHALL discard a read in flight when reset asserts mid-operation; no response is issued after reset.

Verification
REQ-033 SHALL pass: all 4 requesters issue writes continuously -> grants 0,1,2,3,0 on consecutive cycles, sram_enable=1 every cycle.
REQ-034 SHALL pass: requester 2 reads addr 5 (contents 0xA5) with resp_ready=1 -> resp_valid[2]=1 and resp_data=0xA5 at T+2.
REQ-035 SHALL pass: read held with resp_ready=0 for 5 cycles while requester 1 writes -> writes granted, other reads blocked, resp_data stable.
REQ-036 SHALL pass: requester 0 writes addr 3 with mask 0x0001, data 0xFF, then requester 0 reads addr 3 -> only byte 0 updated in the returned word.
REQ-037 SHALL pass: reset asserted the cycle after a read grant -> no resp_valid ever asserted, ptr=0.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one registered-read SRAM port among NUM_REQ requesters.
// Writes are posted; at most one read is in flight, its data parked in a hold register until accepted.
module sram_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_UNIT  = 8,
    parameter int MASK_WIDTH = (DATA_WIDTH + MASK_UNIT - 1) / MASK_UNIT
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_mask,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_dataIn,
    output logic [NUM_REQ-1:0]               resp_valid,
    input  logic [NUM_REQ-1:0]               resp_ready,
    output logic [DATA_WIDTH-1:0]            resp_data,
    output logic                             sram_enable,
    output logic                             sram_write,
    output logic [ADDR_WIDTH-1:0]            sram_addr,
    output logic [MASK_WIDTH-1:0]            sram_mask,
    output logic [DATA_WIDTH-1:0]            sram_dataIn,
    input  logic [DATA_WIDTH-1:0]            sram_dataOut
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]      r_ptr;
    logic                  r_inflight;
    logic [IDX_W-1:0]      r_inflight_id;
    logic                  r_hold_valid;
    logic [IDX_W-1:0]      r_hold_id;
    logic [DATA_WIDTH-1:0] r_hold_data;

    logic                  w_resp_fire;
    logic                  w_read_allowed;
    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [SUM_W-1:0]      w_sum;
    logic [SUM_W-1:0]      w_ptr_sum;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = r_hold_valid && (r_hold_id == IDX_W'(i));
        end
    end

    assign resp_data      = r_hold_data;
    assign w_resp_fire    = |(resp_valid & resp_ready);
    assign w_read_allowed = !r_inflight && (!r_hold_valid || w_resp_fire);
    // Gated by reset so no grant or SRAM access leaks out during a reset cycle.
    assign w_eligible     = req_valid & (req_write | {NUM_REQ{w_read_allowed}}) & {NUM_REQ{!reset}};

    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NUM_REQ)) begin
                w_sum = w_sum - SUM_W'(NUM_REQ);
            end
            if (!w_grant && w_eligible[w_sum[IDX_W-1:0]]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_sum  = {1'b0, w_grant_idx} + SUM_W'(1);
        w_ptr_next = w_ptr_sum[IDX_W-1:0];
        if (w_ptr_sum >= SUM_W'(NUM_REQ)) begin
            w_ptr_next = '0;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_grant && (w_grant_idx == IDX_W'(i));
        end
    end

    always_comb begin
        sram_enable = w_grant;
        sram_write  = 1'b0;
        sram_addr   = '0;
        sram_mask   = '0;
        sram_dataIn = '0;
        if (w_grant) begin
            sram_write  = req_write[w_grant_idx];
            sram_addr   = req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            sram_mask   = req_mask[w_grant_idx*MASK_WIDTH +: MASK_WIDTH];
            sram_dataIn = req_dataIn[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr         <= '0;
            r_inflight    <= 1'b0;
            r_inflight_id <= '0;
            r_hold_valid  <= 1'b0;
            r_hold_id     <= '0;
            r_hold_data   <= '0;
        end else begin
            if (w_grant) begin
                r_ptr <= w_ptr_next;
            end
            if (w_grant && !req_write[w_grant_idx]) begin
                r_inflight    <= 1'b1;
                r_inflight_id <= w_grant_idx;
            end else begin
                r_inflight    <= 1'b0;
            end
            // SRAM read data is valid the cycle after the read grant.
            if (r_inflight) begin
                r_hold_valid <= 1'b1;
                r_hold_id    <= r_inflight_id;
                r_hold_data  <= sram_dataOut;
            end else if (w_resp_fire) begin
                r_hold_valid <= 1'b0;
            end
        end
    end
endmodule
